// File: rtl/i2c_pkg.sv
// i2c_pkg: shared FSM state encoding and byte/bit-count constants for the SPD target.
package i2c_pkg;
  localparam int BYTE_BITS = 8;
  localparam int BIT_W = $clog2(BYTE_BITS);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(BYTE_BITS - 1);
  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, WORD, WORD_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, WAIT_STOP
  } state_t;
endpackage

// File: rtl/i2c_line_filter.sv
// i2c_line_filter: 2-FF synchronizer plus glitch filter; a new level needs FILTER_CYCLES equal samples.
module i2c_line_filter #(
  parameter int FILTER_CYCLES = 3
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_line,
  output logic o_level
);
  localparam int CW = (FILTER_CYCLES < 2) ? 1 : $clog2(FILTER_CYCLES);
  logic [1:0]    r_sync;
  logic [CW-1:0] r_cnt;
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync  <= 2'b11;
      r_cnt   <= '0;
      o_level <= 1'b1;
    end else begin
      r_sync <= {r_sync[0], i_line};
      if (r_sync[1] == o_level) r_cnt <= '0;
      else if (r_cnt == CW'(FILTER_CYCLES - 1)) begin
        o_level <= r_sync[1];
        r_cnt   <= '0;
      end else r_cnt <= r_cnt + CW'(1);
    end
  end
endmodule

// File: rtl/i2c_spd_target.sv
// i2c_spd_target: I2C target with a 256x8 SPD-style memory, word pointer and local config write port.
module i2c_spd_target import i2c_pkg::*; #(
  parameter logic [6:0] DEV_ADDR      = 7'h50,
  parameter int         FILTER_CYCLES = 3,
  parameter bit         ALLOW_WRITE   = 1'b1
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_scl,
  input  logic       i_sda,
  output logic       o_sda_oe,
  input  logic       i_cfg_we,
  input  logic [7:0] i_cfg_addr,
  input  logic [7:0] i_cfg_data,
  output logic       o_busy,
  output logic       o_rd_strobe
);
  logic w_scl, w_sda, r_scl_q, r_sda_q;
  logic w_scl_rise, w_scl_fall, w_start, w_stop;
  logic w_last, w_match, w_data_st, w_ack_st, w_load, w_wr_en;
  logic [7:0] w_byte, w_rd_byte;
  state_t r_state;
  logic [7:0] r_shift, r_ptr;
  logic [BIT_W-1:0] r_bit;
  logic r_rw, r_ack;
  logic [7:0] r_mem [0:255];

  i2c_line_filter #(.FILTER_CYCLES(FILTER_CYCLES)) u_scl (
    .i_clk(i_clk), .i_rst(i_rst), .i_line(i_scl), .o_level(w_scl));
  i2c_line_filter #(.FILTER_CYCLES(FILTER_CYCLES)) u_sda (
    .i_clk(i_clk), .i_rst(i_rst), .i_line(i_sda), .o_level(w_sda));

  assign w_scl_rise = w_scl & ~r_scl_q;
  assign w_scl_fall = ~w_scl & r_scl_q;
  assign w_start    = w_scl & r_scl_q & r_sda_q & ~w_sda;
  assign w_stop     = w_scl & r_scl_q & ~r_sda_q & w_sda;
  assign w_byte     = {r_shift[6:0], w_sda};
  assign w_last     = r_bit == LAST_BIT;
  assign w_match    = r_shift[6:0] == DEV_ADDR;
  assign w_data_st  = r_state inside {ADDR, WORD, WR_DATA, RD_DATA};
  assign w_ack_st   = r_state inside {ADDR_ACK, WORD_ACK, WR_ACK, RD_ACK};
  assign w_load     = (r_state == ADDR_ACK && r_rw) || (r_state == RD_ACK && !r_ack);
  assign w_rd_byte  = r_mem[r_ptr];
  assign w_wr_en    = ALLOW_WRITE && r_state == WR_DATA && w_scl_rise && w_last;

  // Later assignment wins, so the local config port beats an I2C write to the same address.
  always_ff @(posedge i_clk) begin
    if (w_wr_en) r_mem[r_ptr] <= w_byte;
    if (i_cfg_we) r_mem[i_cfg_addr] <= i_cfg_data;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= IDLE;
      o_sda_oe    <= 1'b0;
      o_busy      <= 1'b0;
      o_rd_strobe <= 1'b0;
      r_ptr       <= '0;
      r_shift     <= '0;
      r_bit       <= '0;
      r_rw        <= 1'b0;
      r_ack       <= 1'b0;
      r_scl_q     <= 1'b1;
      r_sda_q     <= 1'b1;
    end else begin
      r_scl_q     <= w_scl;
      r_sda_q     <= w_sda;
      o_rd_strobe <= 1'b0;
      if (w_start) begin
        r_state  <= ADDR;
        r_bit    <= '0;
        r_shift  <= '0;
        o_sda_oe <= 1'b0;
      end else if (w_stop) begin
        r_state  <= IDLE;
        r_bit    <= '0;
        o_sda_oe <= 1'b0;
        o_busy   <= 1'b0;
      end else if (w_scl_rise) begin
        // Read bytes also shift here so the next bit to drive sits in r_shift[7].
        if (w_data_st) begin
          r_shift <= w_byte;
          r_bit   <= w_last ? '0 : r_bit + BIT_W'(1);
          if (w_last)
            case (r_state)
              ADDR: begin
                r_rw    <= w_sda;
                r_state <= w_match ? ADDR_ACK : WAIT_STOP;
                o_busy  <= o_busy | w_match;
              end
              WORD: begin
                r_ptr   <= w_byte;
                r_state <= WORD_ACK;
              end
              WR_DATA: begin
                r_ptr   <= r_ptr + 8'd1;
                r_state <= WR_ACK;
              end
              default: r_state <= RD_ACK;
            endcase
        end else if (w_ack_st) begin
          r_bit <= BIT_W'(1);
          r_ack <= w_sda;
        end
      end else if (w_scl_fall) begin
        // Ack states see two falls: the first opens the ack slot, the second closes it.
        if (r_state == RD_DATA) o_sda_oe <= ~r_shift[7];
        else if (w_ack_st && r_bit == '0) o_sda_oe <= r_state != RD_ACK;
        else if (w_ack_st) begin
          r_bit <= '0;
          if (w_load) begin
            r_state     <= RD_DATA;
            r_shift     <= w_rd_byte;
            o_sda_oe    <= ~w_rd_byte[7];
            r_ptr       <= r_ptr + 8'd1;
            o_rd_strobe <= 1'b1;
          end else begin
            o_sda_oe <= 1'b0;
            r_state  <= (r_state == ADDR_ACK) ? WORD : (r_state == RD_ACK) ? WAIT_STOP : WR_DATA;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_i2c_spd_target.sv
// tb_i2c_spd_target: bit-banged I2C master checked against a byte-array memory model with a wrapping pointer.
module tb_i2c_spd_target;
  localparam int H = 16;
  localparam logic [7:0] AW = 8'hA0, AR = 8'hA1, AX = 8'hA2;
  logic clk = 1'b0, rst = 1'b1, m_scl = 1'b1, m_sda = 1'b1, cfg_we = 1'b0;
  logic [7:0] cfg_addr = 8'h00, cfg_data = 8'h00;
  logic oe, busy, rd_strobe, sda_bus;
  logic [7:0] mmem [256];
  logic [7:0] mptr = 8'h00;
  int n_chk = 0, n_err = 0, strobes = 0, s0, n;
  logic a, b;
  logic [7:0] v, w, xa, di, dc;
  logic [3:0] part;

  assign sda_bus = m_sda & ~oe;
  always #5 clk = ~clk;
  always @(negedge clk) if (rd_strobe === 1'b1) strobes++;

  i2c_spd_target dut (
    .i_clk(clk), .i_rst(rst), .i_scl(m_scl), .i_sda(sda_bus), .o_sda_oe(oe),
    .i_cfg_we(cfg_we), .i_cfg_addr(cfg_addr), .i_cfg_data(cfg_data),
    .o_busy(busy), .o_rd_strobe(rd_strobe));

  task automatic clks(input int k); repeat (k) @(negedge clk); endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic bv, input logic glitch = 1'b0);
    clks(H/2); m_sda = bv; clks(H/2); m_scl = 1'b1; clks(H/2);
    if (glitch) begin m_sda = ~bv; clks(1); m_sda = bv; end
    clks(H/2); m_scl = 1'b0;
  endtask

  task automatic recv_bit(output logic bv);
    clks(H/2); m_sda = 1'b1; clks(H/2); m_scl = 1'b1; clks(H - 1); bv = sda_bus; clks(1); m_scl = 1'b0;
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack, input int gbit = -1);
    for (int i = 7; i >= 0; i--) send_bit(d[i], i == gbit);
    recv_bit(ack);
  endtask

  task automatic read_byte(input logic nack, output logic [7:0] d);
    logic t;
    for (int i = 7; i >= 0; i--) begin recv_bit(t); d[i] = t; end
    send_bit(nack);
  endtask

  task automatic start_c; clks(H/2); m_sda = 1'b1; clks(H/2); m_scl = 1'b1; clks(H); m_sda = 1'b0; clks(H); m_scl = 1'b0; endtask
  task automatic stop_c;  clks(H/2); m_sda = 1'b0; clks(H/2); m_scl = 1'b1; clks(H); m_sda = 1'b1; clks(H); endtask

  task automatic wr_ok(input logic [7:0] d, input string tag, input int gbit = -1);
    logic ack;
    write_byte(d, ack, gbit);
    check(tag, ack, 0);
  endtask

  task automatic set_ptr(input logic [7:0] wa);
    start_c; wr_ok(AW, "addr_w_ack"); wr_ok(wa, "word_ack"); mptr = wa;
  endtask

  task automatic wr_data(input logic [7:0] d, input int gbit = -1);
    wr_ok(d, "data_ack", gbit); mmem[mptr] = d; mptr++;
  endtask

  task automatic rd_data(input logic nack);
    logic [7:0] d;
    read_byte(nack, d); check("read_data", d, mmem[mptr]); mptr++;
  endtask

  task automatic begin_read; start_c; wr_ok(AR, "addr_r_ack"); endtask

  task automatic cfg_write(input logic [7:0] ad, input logic [7:0] d);
    cfg_addr = ad; cfg_data = d; cfg_we = 1'b1; clks(1); cfg_we = 1'b0; mmem[ad] = d;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    clks(3);
    check("reset_oe", oe, 0); check("reset_busy", busy, 0); check("reset_strobe", rd_strobe, 0);
    rst = 1'b0; clks(2);
    for (int i = 0; i < 256; i++) cfg_write(8'(i), 8'(i));
    set_ptr(8'h10); check("busy_matched", busy, 1);
    s0 = strobes; begin_read; rd_data(1'b0); rd_data(1'b0); rd_data(1'b1); stop_c;
    check("rd_strobe_count", strobes - s0, 3); check("idle_busy", busy, 0); check("idle_oe", oe, 0);
    set_ptr(8'hFE); wr_data(8'hAA); wr_data(8'hBB); wr_data(8'hCC); stop_c;
    set_ptr(8'hFE); begin_read; rd_data(1'b0); rd_data(1'b0); rd_data(1'b1); stop_c;
    start_c; write_byte(AX, a); check("nack_addr", a, 1); check("busy_mismatch", busy, 0);
    write_byte(8'h00, a); check("nack_wait", a, 1); stop_c;
    m_sda = 1'b0; clks(1); m_sda = 1'b1; clks(H); check("glitch_busy", busy, 0);
    m_scl = 1'b0; clks(H); write_byte(AW, a); check("glitch_no_start", a, 1); stop_c;
    set_ptr(8'h40); wr_data(8'($urandom) & 8'hF7, 3); wr_data(8'($urandom) | 8'h10, 4); stop_c;
    set_ptr(8'h40); begin_read; rd_data(1'b0); rd_data(1'b1); stop_c;
    xa = 8'($urandom); di = 8'($urandom); dc = ~di;
    set_ptr(xa);
    for (int i = 7; i >= 1; i--) send_bit(di[i]);
    clks(H/2); m_sda = di[0]; clks(H/2); m_scl = 1'b1;
    clks(3); cfg_addr = xa; cfg_data = dc; cfg_we = 1'b1; clks(3); cfg_we = 1'b0;
    clks(H - 6); m_scl = 1'b0;
    recv_bit(a); check("collide_ack", a, 0); stop_c;
    mmem[xa] = dc; mptr = xa + 8'd1;
    set_ptr(xa); begin_read; rd_data(1'b1); stop_c;
    for (int t = 0; t < 4; t++) begin
      w = (t % 2 == 1) ? 8'hFC + 8'($urandom_range(0, 3)) : 8'($urandom);
      n = $urandom_range(1, 4);
      cfg_write(8'($urandom), 8'($urandom));
      set_ptr(w); for (int k = 0; k < n; k++) wr_data(8'($urandom)); stop_c;
      set_ptr(w); begin_read; for (int k = 0; k < n; k++) rd_data(k == n - 1); stop_c;
      begin_read; rd_data(1'b1); stop_c;
    end
    v = 8'($urandom) | 8'h08; cfg_write(8'h20, v);
    set_ptr(8'h20); begin_read;
    for (int i = 3; i >= 0; i--) begin recv_bit(b); part[i] = b; end
    mptr++;
    check("partial_bits", part, v[7:4]);
    stop_c; check("stop_oe", oe, 0); check("stop_busy", busy, 0);
    begin_read; rd_data(1'b1); stop_c;
    v = 8'($urandom) & 8'h7F; cfg_write(8'h30, v);
    set_ptr(8'h30); begin_read; clks(H/2);
    check("pre_reset_drive", oe, 1);
    rst = 1'b1; clks(1);
    check("reset_oe_next", oe, 0); check("reset_busy_mid", busy, 0);
    rst = 1'b0; mptr = 8'h00;
    m_sda = 1'b1; clks(H/2); m_scl = 1'b1; clks(H);
    begin_read; rd_data(1'b1); stop_c;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
